// File: rtl/key_event_arbiter.sv
// key_event_arbiter: shared key-event FIFO with host/UART round-robin read arbitration and a level IRQ; KEY_EVT_OVF_CNT_EN adds a dropped-push counter.
// Latency: earliest grant 2 cycles after the push cycle; at most one event per 3 cycles (IDLE -> SERVE -> RELEASE).
// Backpressure: pushes while full are dropped (full outputs warn the controller); readers are held off by the 4-phase req/grant handshake.
module key_event_arbiter #(
    parameter int ADDR_WIDTH = 3,
    localparam int LVL_WIDTH = ADDR_WIDTH + 1
) (
    input  logic                 system_clk_i,
    input  logic                 system_rst_i,
    input  logic                 fifo_write_enable_i,
    input  logic [5:0]           key_position_data_i,
    input  logic [7:0]           key_ascii_data_i,
    output logic                 position_fifo_full_o,
    output logic                 keycode_fifo_full_o,
    input  logic                 host_req_i,
    input  logic                 uart_req_i,
    output logic                 host_grant_o,
    output logic                 uart_grant_o,
    output logic                 rd_valid_o,
    output logic [5:0]           rd_position_o,
    output logic [7:0]           rd_ascii_o,
    output logic [LVL_WIDTH-1:0] fifo_level_o,
    input  logic [LVL_WIDTH-1:0] irq_threshold_i,
    output logic                 key_event_irq_o
`ifdef KEY_EVT_OVF_CNT_EN
    ,
    output logic [7:0]           ovf_count_o
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE   = 2'b01,
        RELEASE = 2'b10
    } state_t;

    typedef enum logic {
        OWN_HOST = 1'b0,
        OWN_UART = 1'b1
    } owner_t;

    logic [5:0]            pos_mem   [DEPTH];
    logic [7:0]            ascii_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [LVL_WIDTH-1:0]  level;
    state_t                state;
    state_t                state_nxt;
    owner_t                last_owner;
    owner_t                pick;
    logic                  start;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  owner_req;

    assign full                 = (level == FULL_LVL);
    assign position_fifo_full_o = full;
    assign keycode_fifo_full_o  = full;
    assign fifo_level_o         = level;
    assign push                 = fifo_write_enable_i && !full;
    assign pop                  = (state == SERVE);
    assign rd_valid_o           = pop;
    // last_owner doubles as the current owner while in SERVE/RELEASE
    assign host_grant_o         = pop && (last_owner == OWN_HOST);
    assign uart_grant_o         = pop && (last_owner == OWN_UART);
    assign owner_req            = (last_owner == OWN_HOST) ? host_req_i : uart_req_i;

    always_comb begin
        state_nxt = state;
        pick      = last_owner;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (level != '0 && (host_req_i || uart_req_i)) begin
                    start     = 1'b1;
                    state_nxt = SERVE;
                    if (host_req_i && uart_req_i) begin
                        pick = (last_owner == OWN_UART) ? OWN_HOST : OWN_UART;
                    end else if (host_req_i) begin
                        pick = OWN_HOST;
                    end else begin
                        pick = OWN_UART;
                    end
                end
            end
            SERVE:   state_nxt = RELEASE;
            RELEASE: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge system_clk_i) begin
        if (system_rst_i) begin
            state           <= IDLE;
            last_owner      <= OWN_UART;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            level           <= '0;
            rd_position_o   <= '0;
            rd_ascii_o      <= '0;
            key_event_irq_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                last_owner    <= pick;
                rd_position_o <= pos_mem[rd_ptr];
                rd_ascii_o    <= ascii_mem[rd_ptr];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (!push && pop) begin
                level <= level - 1'b1;
            end
            key_event_irq_o <= (irq_threshold_i != '0) && (level >= irq_threshold_i);
        end
    end

    // Storage needs no reset: pointers and level define what is valid.
    always_ff @(posedge system_clk_i) begin
        if (!system_rst_i && push) begin
            pos_mem[wr_ptr]   <= key_position_data_i;
            ascii_mem[wr_ptr] <= key_ascii_data_i;
        end
    end

`ifdef KEY_EVT_OVF_CNT_EN
    always_ff @(posedge system_clk_i) begin
        if (system_rst_i) begin
            ovf_count_o <= '0;
        end else if (fifo_write_enable_i && full && ovf_count_o != 8'hFF) begin
            ovf_count_o <= ovf_count_o + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: stimulus queues expected pops, a negedge monitor checks every grant.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic [5:0] pos = '0;
    logic [7:0] asc = '0;
    logic       host_req = 1'b0;
    logic       uart_req = 1'b0;
    logic [3:0] thr = '0;

    logic       pos_full;
    logic       key_full;
    logic       host_grant;
    logic       uart_grant;
    logic       rd_valid;
    logic [5:0] rd_pos;
    logic [7:0] rd_asc;
    logic [3:0] level;
    logic       irq;
`ifdef KEY_EVT_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    typedef struct packed {
        logic       uart;
        logic [5:0] pos;
        logic [7:0] asc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic who;

    always #5 clk = ~clk;

    key_event_arbiter #(.ADDR_WIDTH(3)) dut (
        .system_clk_i         (clk),
        .system_rst_i         (rst),
        .fifo_write_enable_i  (we),
        .key_position_data_i  (pos),
        .key_ascii_data_i     (asc),
        .position_fifo_full_o (pos_full),
        .keycode_fifo_full_o  (key_full),
        .host_req_i           (host_req),
        .uart_req_i           (uart_req),
        .host_grant_o         (host_grant),
        .uart_grant_o         (uart_grant),
        .rd_valid_o           (rd_valid),
        .rd_position_o        (rd_pos),
        .rd_ascii_o           (rd_asc),
        .fifo_level_o         (level),
        .irq_threshold_i      (thr),
        .key_event_irq_o      (irq)
`ifdef KEY_EVT_OVF_CNT_EN
        ,
        .ovf_count_o          (ovf_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Any grant strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rd_valid || host_grant || uart_grant) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got host=%0b uart=%0b valid=%0b, expected no grant",
                         host_grant, uart_grant, rd_valid);
            end else begin
                mon_e = exp_q.pop_front();
                check("grant_owner", {29'd0, host_grant, uart_grant, rd_valid},
                      mon_e.uart ? 32'h3 : 32'h5);
                check("rd_position", {26'd0, rd_pos}, {26'd0, mon_e.pos});
                check("rd_ascii", {24'd0, rd_asc}, {24'd0, mon_e.asc});
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        we = 1'b0;
        host_req = 1'b0;
        uart_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [5:0] p, input logic [7:0] a);
        we = 1'b1;
        pos = p;
        asc = a;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wait_grant(input string name, output logic got_uart);
        int n;
        n = 0;
        got_uart = 1'b0;
        @(negedge clk);
        while (!rd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rd_valid) begin
            failures++;
            $display("FAIL %s: got no grant in 20 cycles, expected a grant", name);
        end else begin
            got_uart = uart_grant;
        end
    endtask

    initial begin
        do_reset();
        check("rst_level", {28'd0, level}, 0);
        check("rst_strobes", {28'd0, host_grant, uart_grant, rd_valid, irq}, 0);
        check("rst_full", {30'd0, pos_full, key_full}, 0);
        check("rst_rd_data", {18'd0, rd_pos, rd_asc}, 0);
`ifdef KEY_EVT_OVF_CNT_EN
        check("rst_ovf", {24'd0, ovf_count}, 0);
`endif

        // Single push, host holding its request: grant two cycles after the push.
        host_req = 1'b1;
        exp_q.push_back({1'b0, 6'o25, 8'h55});
        push(6'o25, 8'h55);
        check("t1_level_push", {28'd0, level}, 1);
        check("t1_no_early_grant", {31'd0, rd_valid}, 0);
        @(negedge clk);
        check("t1_grant_latency", {31'd0, host_grant}, 1);
        host_req = 1'b0;
        @(negedge clk);
        check("t1_level_pop", {28'd0, level}, 0);
        check("t1_rd_hold", {18'd0, rd_pos, rd_asc}, {18'd0, 6'o25, 8'h55});
        @(negedge clk);

        // Both requesters contend: host, UART, host in FIFO order.
        do_reset();
        push(6'o01, 8'h61);
        push(6'o12, 8'h62);
        push(6'o23, 8'h63);
        exp_q.push_back({1'b0, 6'o01, 8'h61});
        exp_q.push_back({1'b1, 6'o12, 8'h62});
        exp_q.push_back({1'b0, 6'o23, 8'h63});
        host_req = 1'b1;
        uart_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant("t2_grant", who);
            if (who) uart_req = 1'b0; else host_req = 1'b0;
            repeat (2) @(negedge clk);
            if (who) uart_req = 1'b1; else host_req = 1'b1;
        end
        host_req = 1'b0;
        uart_req = 1'b0;
        repeat (3) @(negedge clk);
        check("t2_level_drained", {28'd0, level}, 0);

        // Fill to DEPTH and overflow by one.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(6'(i), 8'h30 + 8'(i));
            if (i == 6) check("t3_not_full_7", {30'd0, pos_full, key_full}, 0);
            if (i == 7) check("t3_full_8", {30'd0, pos_full, key_full}, 32'h3);
        end
        check("t3_level_9th_dropped", {28'd0, level}, 8);
`ifdef KEY_EVT_OVF_CNT_EN
        check("t3_ovf", {24'd0, ovf_count}, 1);
`endif

        // Push lands on the SERVE pop edge while full: dropped.
        exp_q.push_back({1'b0, 6'd0, 8'h30});
        host_req = 1'b1;
        wait_grant("t5_grant", who);
        push(6'o77, 8'hEE);
        host_req = 1'b0;
        check("t5_level", {28'd0, level}, 7);
        check("t5_not_full", {31'd0, pos_full}, 0);
`ifdef KEY_EVT_OVF_CNT_EN
        check("t5_ovf", {24'd0, ovf_count}, 2);
`endif
        // Write pointer has wrapped; drain everything in order.
        push(6'o70, 8'h7A);
        for (int j = 1; j < 8; j++) exp_q.push_back({1'b0, 6'(j), 8'h30 + 8'(j)});
        exp_q.push_back({1'b0, 6'o70, 8'h7A});
        for (int j = 0; j < 8; j++) begin
            host_req = 1'b1;
            wait_grant("t5_drain", who);
            host_req = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("t5_level_drained", {28'd0, level}, 0);

        // Level interrupt at threshold 3, then disabled.
        do_reset();
        thr = 4'd3;
        push(6'o11, 8'h41);
        push(6'o22, 8'h42);
        push(6'o33, 8'h43);
        check("t4_irq_not_yet", {31'd0, irq}, 0);
        @(negedge clk);
        check("t4_irq_set", {31'd0, irq}, 1);
        exp_q.push_back({1'b0, 6'o11, 8'h41});
        host_req = 1'b1;
        wait_grant("t4_grant", who);
        host_req = 1'b0;
        @(negedge clk);
        check("t4_irq_still", {31'd0, irq}, 1);
        @(negedge clk);
        check("t4_irq_clear", {31'd0, irq}, 0);
        check("t4_level", {28'd0, level}, 2);
        thr = 4'd0;
        push(6'o44, 8'h44);
        push(6'o55, 8'h45);
        repeat (2) @(negedge clk);
        check("t4_irq_disabled", {31'd0, irq}, 0);

        // Reset while in SERVE with 4 queued.
        do_reset();
        push(6'o01, 8'h21);
        push(6'o02, 8'h22);
        push(6'o03, 8'h23);
        push(6'o04, 8'h24);
        exp_q.push_back({1'b0, 6'o01, 8'h21});
        host_req = 1'b1;
        wait_grant("t6_grant", who);
        rst = 1'b1;
        @(negedge clk);
        check("t6_grants_low", {29'd0, host_grant, uart_grant, rd_valid}, 0);
        check("t6_level", {28'd0, level}, 0);
        check("t6_rd_data", {18'd0, rd_pos, rd_asc}, 0);
        rst = 1'b0;
        host_req = 1'b0;
        push(6'o66, 8'h5A);
        exp_q.push_back({1'b0, 6'o66, 8'h5A});
        host_req = 1'b1;
        uart_req = 1'b1;
        wait_grant("t6_tie", who);
        check("t6_host_wins_tie", {31'd0, who}, 0);
        host_req = 1'b0;
        uart_req = 1'b0;
        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
